main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/main_control_fsm.sv | 122 ++++++++++++
 tb/tb_main_control_fsm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU control path: states, opcodes and
// datapath select codes used by the main control FSM.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEMRD  = 4'd3,
    S_LDWB   = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_BRANCH = 4'd7,
    S_ALUWB  = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000110;
  localparam logic [5:0] OP_BGT   = 6'b001000;
  localparam logic [5:0] OP_BLT   = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b001010;
  localparam logic [5:0] OP_BNE   = 6'b001011;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BGT) || (op == OP_BLT) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memReady-low cycles in a memory-wait state and flags a
// timeout on the cycle that would be the MEM_WAIT_MAX-th such cycle.
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait_state,
  input  logic i_mem_ready,
  output logic o_timeout
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT_MAX - 1);

  logic [CW-1:0] r_count;

  // memReady in the final allowed cycle completes the access, so no timeout.
  assign o_timeout = i_wait_state && !i_mem_ready && (r_count == LAST);

  // Inside a wait state, the FSM leaves exactly when memReady is high or on
  // timeout, so those conditions stand in for "state changed".
  always_ff @(posedge clk) begin
    if (reset || !i_wait_state || i_mem_ready || o_timeout) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle CPU main control FSM with memory-wait timeout (busErr).
// Define ILLEGAL_OP_TRAP_EN to send illegal opcodes to a sticky TRAP state.
module main_control_fsm
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic [3:0] state,
  output logic       pcWriteUncond,
  output logic       irWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWrite,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       busErr,
  output logic       trap
);

  state_t r_state;
  logic   r_bus_err;
  logic   w_wait_state;
  logic   w_timeout;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk         (clk),
    .reset       (reset),
    .i_wait_state(w_wait_state),
    .i_mem_ready (memReady),
    .o_timeout   (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_bus_err <= 1'b0;
    end else if (w_timeout) begin
      r_state   <= S_FETCH;
      r_bus_err <= 1'b1;
    end else begin
      case (r_state)
        S_FETCH:  if (memReady) r_state <= S_DECODE;
        S_DECODE: begin
          if (opcode == OP_LW || opcode == OP_SW)          r_state <= S_ADDR;
          else if (opcode == OP_RTYPE || opcode == OP_ADDI) r_state <= S_EXEC;
          else if (is_branch(opcode))                       r_state <= S_BRANCH;
          else if (opcode == OP_J)                          r_state <= S_JUMP;
          else begin
`ifdef ILLEGAL_OP_TRAP_EN
            r_state <= S_TRAP;
`else
            r_state <= S_FETCH;
`endif
          end
        end
        S_ADDR:   r_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (memReady) r_state <= S_LDWB;
        S_MEMWR:  if (memReady) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pcWriteUncond = 1'b0;
    irWrite       = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    regWrite      = 1'b0;
    aluSrcB       = SRCB_REG;
    aluOp         = ALU_ADD;
    pcSource      = PC_ALU;
    case (r_state)
      S_FETCH: begin
        memRead       = 1'b1;
        aluSrcB       = SRCB_FOUR;
        irWrite       = memReady;
        pcWriteUncond = memReady;
      end
      S_DECODE: aluSrcB  = SRCB_BOFF;
      S_ADDR:   aluSrcB  = SRCB_IMM;
      S_MEMRD:  memRead  = 1'b1;
      S_LDWB:   regWrite = 1'b1;
      S_MEMWR:  memWrite = 1'b1;
      S_EXEC: begin
        if (opcode == OP_RTYPE) aluOp = ALU_FUNCT;
        else                    aluSrcB = SRCB_IMM;
      end
      S_BRANCH: begin
        aluOp    = ALU_SUB;
        pcSource = PC_BRANCH;
      end
      S_ALUWB:  regWrite = 1'b1;
      S_JUMP: begin
        pcWriteUncond = 1'b1;
        pcSource      = PC_JUMP;
      end
      default: ;
    endcase
  end

  assign state  = r_state;
  assign busErr = r_bus_err;

`ifdef ILLEGAL_OP_TRAP_EN
  assign trap = (r_state == S_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: per-cycle behavioural model compare plus
// directed instruction walks with literal state sequences.
module tb_main_control_fsm;

  localparam int MEM_WAIT_MAX = 15;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam int ILLEGAL_DEST = 10;
`else
  localparam int ILLEGAL_DEST = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       memReady = 1'b0;
  logic [3:0] state;
  logic       pcWriteUncond, irWrite, memRead, memWrite, regWrite, busErr, trap;
  logic [1:0] aluSrcB, aluOp, pcSource;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  main_control_fsm #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
    .state(state), .pcWriteUncond(pcWriteUncond), .irWrite(irWrite),
    .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
    .busErr(busErr), .trap(trap)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_state = 0;
  int m_wait = 0;
  bit m_bus = 1'b0;
  bit chk_en = 1'b0;

  function automatic int succ(input int s, input logic [5:0] op, input logic rdy);
    case (s)
      0: return rdy ? 1 : 0;
      1: begin
        if (op == 6'd4 || op == 6'd5) return 2;
        if (op == 6'd0 || op == 6'd1) return 6;
        if (op >= 6'd8 && op <= 6'd11) return 7;
        if (op == 6'd6) return 9;
        return ILLEGAL_DEST;
      end
      2: return (op == 6'd4) ? 3 : 5;
      3: return rdy ? 4 : 3;
      5: return rdy ? 0 : 5;
      6: return 8;
      10: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic logic [16:0] exp_vec(input int s, input logic [5:0] op,
                                          input logic rdy, input logic bus);
    logic pcw, irw, mr, mw, rw, tr;
    logic [1:0] sb, ao, ps;
    pcw = 0; irw = 0; mr = 0; mw = 0; rw = 0; tr = 0; sb = 0; ao = 0; ps = 0;
    case (s)
      0: begin mr = 1; sb = 2'd1; pcw = rdy; irw = rdy; end
      1: sb = 2'd3;
      2: sb = 2'd2;
      3: mr = 1;
      4: rw = 1;
      5: mw = 1;
      6: if (op == 6'd0) ao = 2'd2; else sb = 2'd2;
      7: begin ao = 2'd1; ps = 2'd1; end
      8: rw = 1;
      9: begin pcw = 1; ps = 2'd2; end
      10: tr = 1;
      default: ;
    endcase
    return {pcw, irw, mr, mw, rw, sb, ao, ps, tr, bus, 4'(s)};
  endfunction

  always @(posedge clk) begin : model
    int nxt;
    bit waiting;
    if (reset) begin
      m_state = 0; m_wait = 0; m_bus = 0; chk_en = 1'b1;
    end else begin
      waiting = (m_state == 0 || m_state == 3 || m_state == 5);
      if (waiting && !memReady && m_wait == MEM_WAIT_MAX - 1) begin
        m_state = 0; m_wait = 0; m_bus = 1;
      end else begin
        nxt = succ(m_state, opcode, memReady);
        m_wait = (waiting && !memReady && nxt == m_state) ? m_wait + 1 : 0;
        m_state = nxt;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [16:0] e, a;
    if (chk_en) begin
      e = exp_vec(m_state, opcode, memReady, m_bus);
      a = {pcWriteUncond, irWrite, memRead, memWrite, regWrite, aluSrcB, aluOp,
           pcSource, trap, busErr, state};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t: dut=%h required=%h", $time, a, e);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_seq(input string name, input logic [5:0] op);
    opcode = op;
    memReady = 1'b1;
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      check({name, ".state"}, int'(state), exp_q[i]);
      check({name, ".regWrite"}, int'(regWrite), (exp_q[i] == 4 || exp_q[i] == 8) ? 1 : 0);
      if (exp_q[i] == 7) begin
        check({name, ".pcSource"}, int'(pcSource), 1);
        check({name, ".aluOp"}, int'(aluOp), 1);
        check({name, ".pcWriteUncond"}, int'(pcWriteUncond), 0);
      end
      if (exp_q[i] == 9) begin
        check({name, ".pcWriteUncond"}, int'(pcWriteUncond), 1);
        check({name, ".pcSource"}, int'(pcSource), 2);
      end
      if (exp_q[i] == 6) check({name, ".aluOp"}, int'(aluOp), (op == 6'd0) ? 2 : 0);
      if (exp_q[i] == 10) check({name, ".trap"}, int'(trap), 1);
    end
    $display("txn %s: walked %0d states", name, exp_q.size());
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    exp_q = {0, 1, 2, 3, 4, 0};    run_seq("lw",    6'b000100);
    exp_q = {0, 1, 2, 5, 0};       run_seq("sw",    6'b000101);
    exp_q = {0, 1, 6, 8, 0};       run_seq("rtype", 6'b000000);
    exp_q = {0, 1, 6, 8, 0};       run_seq("addi",  6'b000001);
    exp_q = {0, 1, 7, 0};          run_seq("beq",   6'b001010);
    exp_q = {0, 1, 7, 0};          run_seq("bgt",   6'b001000);
    exp_q = {0, 1, 9, 0};          run_seq("j",     6'b000110);
`ifdef ILLEGAL_OP_TRAP_EN
    exp_q = {0, 1, 10, 10, 10};    run_seq("illegal", 6'b111111);
    do_reset();
    check("illegal.post_reset_state", int'(state), 0);
    check("illegal.post_reset_trap", int'(trap), 0);
`else
    exp_q = {0, 1, 0};             run_seq("illegal", 6'b111111);
    check("illegal.trap", int'(trap), 0);
`endif

    // FETCH timeout: 15 memReady-low cycles raise busErr, irWrite never set
    opcode = 6'b000100; memReady = 1'b0;
    do_reset();
    for (int i = 1; i <= MEM_WAIT_MAX; i++) begin
      step();
      check("fetch_to.state", int'(state), 0);
      check("fetch_to.irWrite", int'(irWrite), 0);
      check("fetch_to.busErr", int'(busErr), (i == MEM_WAIT_MAX) ? 1 : 0);
    end
    memReady = 1'b1;
    step();
    check("fetch_to.sticky_busErr", int'(busErr), 1);
    check("fetch_to.resume_state", int'(state), 1);
    $display("txn fetch_timeout: %0d low cycles", MEM_WAIT_MAX);

    // memReady arriving in the last allowed cycle wins
    memReady = 1'b0;
    do_reset();
    repeat (MEM_WAIT_MAX - 1) step();
    check("fetch_edge.state", int'(state), 0);
    memReady = 1'b1;
    step();
    check("fetch_edge.state_after", int'(state), 1);
    check("fetch_edge.busErr", int'(busErr), 0);
    $display("txn fetch_edge: ready on last allowed cycle");

    // MEMRD timeout returns to FETCH with busErr
    opcode = 6'b000100; memReady = 1'b1;
    do_reset();
    repeat (3) step();
    check("memrd_to.enter", int'(state), 3);
    memReady = 1'b0;
    for (int i = 1; i <= MEM_WAIT_MAX; i++) begin
      step();
      check("memrd_to.state", int'(state), (i == MEM_WAIT_MAX) ? 0 : 3);
      check("memrd_to.busErr", int'(busErr), (i == MEM_WAIT_MAX) ? 1 : 0);
    end
    $display("txn memrd_timeout: %0d low cycles", MEM_WAIT_MAX);

    // reset in the middle of a MEMWR wait
    opcode = 6'b000101; memReady = 1'b1;
    do_reset();
    repeat (3) step();
    memReady = 1'b0;
    repeat (4) step();
    check("memwr_rst.wait_state", int'(state), 5);
    check("memwr_rst.wait_memWrite", int'(memWrite), 1);
    reset = 1'b1;
    step();
    check("memwr_rst.state", int'(state), 0);
    check("memwr_rst.memWrite", int'(memWrite), 0);
    check("memwr_rst.busErr", int'(busErr), 0);
    reset = 1'b0;
    memReady = 1'b1;
    repeat (3) step();
    $display("txn memwr_reset: reset during wait");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
